serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4: operand and difference width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  minuend; sampled only when start is accepted.
REQ-006 b  input  WIDTH  subtrahend; sampled only when start is accepted.
REQ-007 bin  input  1  borrow-in; sampled only when start is accepted.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  one-cycle pulse; indicates that diff, bout and ovf hold a new result.
REQ-010 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  borrow-out: 1 when a < b + bin, unsigned.
REQ-012 ovf  output  1  two's-complement overflow of a - b - bin.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge is accepted; the block latches a, b and bin into internal working registers, clears the bit counter and moves to RUN.
REQ-015 RUN: processes one bit per cycle, LSB first, for exactly WIDTH cycles.
  - Per bit i: d_i = a_i ^ b_i ^ br.
  - Next borrow: br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - Initial br = latched bin.
REQ-016 RUN: after the WIDTH-th bit, the FSM moves to DONE.
  - diff, bout and ovf update from the working registers on the same edge.
  - ovf = (borrow into MSB) ^ (borrow out of MSB).
REQ-017 DONE lasts exactly one cycle: done=1, busy=0; the FSM then returns to IDLE unless start is accepted.
REQ-018 Latency: start accepted at edge k.
  - busy=1 after edge k.
  - busy=0 and done=1 after edge k+WIDTH.
  - done=0 after edge k+WIDTH+1.
REQ-019 start SHALL also be accepted in DONE.
  - Back-to-back operation: done=1 and busy=0 in that cycle; busy=1 after the next edge.
  - No idle cycle between operations.
REQ-020 start during RUN is ignored; changes to a, b or bin during RUN do not affect the result in progress.
REQ-021 diff, bout and ovf hold the last completed result until the next completion; they SHALL NOT show partial results during RUN.
REQ-022 busy and done are never high in the same cycle.
REQ-023 The bit counter SHALL be wide enough to count to WIDTH without wrap; it SHALL NOT wrap during RUN.

Reset
REQ-024 rst_n=0, at any time and independent of clk, forces:
  - FSM to IDLE;
  - busy=0, done=0, diff=0, bout=0, ovf=0;
  - working registers and bit counter to 0.
REQ-025 Reset during RUN abandons the operation; no done pulse follows.
REQ-026 After rst_n returns high, the first rising edge with start=1 is accepted.

Verification (WIDTH=4)
REQ-027 a=0101, b=0011, bin=0, start pulse -> after 4 edges: done=1, diff=0010, bout=0, ovf=0; busy high for exactly 4 cycles.
REQ-028 a=0000, b=0001, bin=0 -> diff=1111, bout=1, ovf=0.
REQ-029 a=1000, b=0001, bin=0 -> diff=0111, bout=0, ovf=1; then a=0111, b=1111, bin=1 started in the DONE cycle -> diff=0111, bout=1, ovf=0, and the second done arrives 4 cycles after the first.
REQ-030 Start 0101-0011; on RUN cycle 2, pulse start with a=1111, b=0000 -> the single done reports diff=0010, and no second operation runs.
REQ-031 Start 0101-0011; assert rst_n=0 mid-RUN between edges -> all outputs 0 immediately, no done; after release, a new start 0110-0010 -> diff=0100, bout=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial subtractor computing a - b - bin, one bit per clock, LSB first.
// Latency : start accepted at edge k -> done pulse after edge k+WIDTH; a new start may be taken in the done cycle.
// Backpres: start is honoured only when not busy (IDLE or DONE); start during RUN is dropped.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a subtraction (accepted in IDLE or DONE)
//   a      in   [WIDTH] minuend, captured on accepted start
//   b      in   [WIDTH] subtrahend, captured on accepted start
//   bin    in   borrow-in, captured on accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, diff/bout/ovf hold a new result
//   diff   out  [WIDTH] (a - b - bin) mod 2^WIDTH
//   bout   out  unsigned borrow-out
//   ovf    out  two's-complement overflow
//
// WIDTH legal range is 2..16.

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // Counter must hold the value WIDTH so it never wraps while running.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // minuend, shifted right each bit
  logic [WIDTH-1:0] b_q, b_d;       // subtrahend, shifted right each bit
  logic [WIDTH-1:0] acc_q, acc_d;   // partial difference, filled from the MSB end
  logic             br_q, br_d;     // running borrow
  logic [CW-1:0]    cnt_q, cnt_d;   // bits processed so far
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // Current bit slice of the subtraction.
  logic bit_a, bit_b, bit_d, br_next;
  logic accept;

  assign bit_a   = a_q[0];
  assign bit_b   = b_q[0];
  assign bit_d   = bit_a ^ bit_b ^ br_q;
  assign br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

  // A new operation may start from IDLE or directly out of DONE.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        acc_d = {bit_d, acc_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // On the MSB, br_q is the borrow into the MSB and br_next the
          // borrow out of it; their XOR is the signed overflow.
          diff_d  = {bit_d, acc_q[WIDTH-1:1]};
          bout_d  = br_next;
          ovf_d   = br_q ^ br_next;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status decoded straight from state so reset clears them without waiting for a clock.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

  // busy and done are mutually exclusive by construction of the state decode.
  a_busy_done_excl : assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));

  // The counter never passes WIDTH while running.
  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
                                 (state_q == RUN) |-> (cnt_q <= LAST_BIT));

endmodule

// File: tb/tb_serial_subtractor.sv
// Purpose : scoreboard bench for serial_subtractor at WIDTH=4 using directed vectors.
// Latency : expected results are queued at start; the monitor pops one per done pulse.
// Backpres: none; the bench drives start only in IDLE/DONE except for the deliberate ignored-start case.

module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  res_t exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      res_t e;
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got diff=%0h bout=%0b ovf=%0b with nothing expected",
                 diff, bout, ovf);
      end else begin
        e = exp_q.pop_front();
        check("result", {26'd0, diff, bout, ovf}, {26'd0, e.diff, e.bout, e.ovf});
      end
    end
  end

  // Drive a start for one edge; returns 1 time unit after the accepting edge.
  task automatic do_start(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini);
    a     = ai;
    b     = bi;
    bin   = bini;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done (bounded), counting busy and non-busy cycles seen before it.
  task automatic wait_done(input string name, output int nbusy, output int nidle);
    bit ok;
    nbusy = 0;
    nidle = 0;
    ok    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nbusy++;
      else      nidle++;
    end
    check({name, "_done_seen"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int nb, ni, cnt;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;

    // Reset state.
    #22;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {28'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5 - 3 = 2; busy for exactly four cycles.
    exp_q.push_back('{diff: 4'b0010, bout: 1'b0, ovf: 1'b0});
    do_start(4'b0101, 4'b0011, 1'b0);
    check("op1_busy_after_start", {31'd0, busy}, 32'd1);
    wait_done("op1", nb, ni);
    check("op1_busy_cycles", nb, 32'd4);
    check("op1_idle_cycles", ni, 32'd0);
    @(negedge clk);
    check("op1_done_one_cycle", {31'd0, done}, 32'd0);

    // 0 - 1 wraps to 1111 with borrow; previous result must hold during RUN.
    exp_q.push_back('{diff: 4'b1111, bout: 1'b1, ovf: 1'b0});
    do_start(4'b0000, 4'b0001, 1'b0);
    @(negedge clk);
    check("op2_diff_held_in_run", {28'd0, diff}, 32'h2);
    wait_done("op2", nb, ni);
    repeat (2) @(negedge clk);

    // -8 - 1 overflows; second op started in the DONE cycle, 7 - 15 - 1.
    exp_q.push_back('{diff: 4'b0111, bout: 1'b0, ovf: 1'b1});
    do_start(4'b1000, 4'b0001, 1'b0);
    wait_done("op3", nb, ni);
    exp_q.push_back('{diff: 4'b0111, bout: 1'b1, ovf: 1'b0});
    do_start(4'b0111, 4'b1111, 1'b1);
    check("op4_busy_after_b2b_start", {31'd0, busy}, 32'd1);
    wait_done("op4", nb, ni);
    check("op4_busy_between_dones", nb, 32'd4);
    check("op4_idle_between_dones", ni, 32'd0);
    repeat (2) @(negedge clk);

    // Start pulsed during RUN cycle 2 with different operands is ignored.
    exp_q.push_back('{diff: 4'b0010, bout: 1'b0, ovf: 1'b0});
    do_start(4'b0101, 4'b0011, 1'b0);
    do_start(4'b1111, 4'b0000, 1'b0);
    a = 4'b1010;
    b = 4'b0110;
    wait_done("op5", nb, ni);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    check("op5_no_second_op", cnt, 32'd0);

    // Reset mid-RUN abandons the operation; outputs clear at once.
    do_start(4'b0101, 4'b0011, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {28'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, bout}, 32'd0);
    check("midrst_ovf",  {31'd0, ovf},  32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    check("midrst_no_done", cnt, 32'd0);

    // First start after reset release is accepted: 6 - 2 = 4.
    exp_q.push_back('{diff: 4'b0100, bout: 1'b0, ovf: 1'b0});
    do_start(4'b0110, 4'b0010, 1'b0);
    check("op6_busy_after_start", {31'd0, busy}, 32'd1);
    wait_done("op6", nb, ni);
    check("op6_busy_cycles", nb, 32'd4);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
